// File: rtl/bytestream_ps2_pkg.sv
// Shared constants for the PS/2 byte-stream bridge: FSM encodings, frame length,
// and the clock-rate divisors that give the 100 us inhibit and the 2 ms line timeout.
package bytestream_ps2_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RX         = 3'd1;
    localparam logic [2:0] ST_TX_INHIBIT = 3'd2;
    localparam logic [2:0] ST_TX_START   = 3'd3;
    localparam logic [2:0] ST_TX_BITS    = 3'd4;
    localparam logic [2:0] ST_TX_ACK     = 3'd5;
    localparam logic [2:0] ST_TX_WAITREL = 3'd6;

    localparam int FRAME_LEN   = 11;
    localparam int TX_BITS_LEN = 10;
    localparam int INHIBIT_DIV = 10000;
    localparam int TIMEOUT_DIV = 500;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/bytestream_ps2_line_sync.sv
// Two-flop synchroniser for one open-drain PS/2 line plus rise/fall pulses
// derived from the synchronised level. Flops reset high to match an idle line.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_sync,
    output logic fall,
    output logic rise
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = line_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign line_sync = sync_q;
    assign fall      = prev_q & ~sync_q;
    assign rise      = ~prev_q & sync_q;

endmodule

// File: rtl/bytestream_ps2.sv
// PS/2 host-side bridge between a byte stream and the CLK/DATA open-drain lines.
// Define BYTESTREAM_PS2_PARITY_CHECK_EN to also reject received frames with bad odd parity.
module bytestream_ps2
    import bytestream_ps2_pkg::*;
#(
    parameter int CLK_RATE = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_pd,
    input  logic       ps2_dat_in,
    output logic       ps2_dat_pd,
    input  logic [7:0] bs_data_in,
    input  logic       bs_data_in_valid,
    output logic       bs_data_in_consume,
    output logic [7:0] bs_data_out,
    output logic       bs_data_out_produce
);
    localparam int INHIBIT_CYC = CLK_RATE / INHIBIT_DIV;
    localparam int TIMEOUT_CYC = CLK_RATE / TIMEOUT_DIV;
    localparam int MAX_CYC     = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int TW          = $clog2(MAX_CYC + 1);

    logic clk_s, clk_fall, clk_rise;
    logic dat_s, dat_fall, dat_rise;
    logic unused_dat_edges;

    ps2_line_sync u_clk_sync (
        .clk(clk), .rst(reset), .line_in(ps2_clk_in),
        .line_sync(clk_s), .fall(clk_fall), .rise(clk_rise)
    );
    ps2_line_sync u_dat_sync (
        .clk(clk), .rst(reset), .line_in(ps2_dat_in),
        .line_sync(dat_s), .fall(dat_fall), .rise(dat_rise)
    );
    assign unused_dat_edges = dat_fall | dat_rise;

    logic [2:0]    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [10:0]   rx_shift_q, rx_shift_d, rx_shift_next;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic          dat_pd_q, dat_pd_d;
    logic          consume_q, consume_d;
    logic          produce_q, produce_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          parity_ok, frame_ok;

    // Receive shift is LSB-first: after 11 bits [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    assign rx_shift_next = {dat_s, rx_shift_q[10:1]};
`ifdef BYTESTREAM_PS2_PARITY_CHECK_EN
    assign parity_ok = ^rx_shift_next[9:1];
`else
    assign parity_ok = 1'b1;
`endif
    assign frame_ok = ~rx_shift_next[0] & rx_shift_next[10] & parity_ok;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        dat_pd_d   = dat_pd_q;
        consume_d  = 1'b0;
        produce_d  = 1'b0;
        data_out_d = data_out_q;
        tmr_d      = (clk_fall || clk_rise) ? '0 : tmr_q + TW'(1);

        case (state_q)
            ST_IDLE: begin
                tmr_d     = '0;
                bit_cnt_d = '0;
                dat_pd_d  = 1'b0;
                if (clk_fall) begin
                    state_d    = ST_RX;
                    rx_shift_d = rx_shift_next;
                    bit_cnt_d  = 4'd1;
                end else if (bs_data_in_valid && clk_s && dat_s) begin
                    tx_shift_d = {1'b1, odd_parity(bs_data_in), bs_data_in};
                    consume_d  = 1'b1;
                    state_d    = ST_TX_INHIBIT;
                end
            end
            ST_RX: begin
                if (clk_fall) begin
                    rx_shift_d = rx_shift_next;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(FRAME_LEN - 1)) begin
                        state_d = ST_IDLE;
                        if (frame_ok) begin
                            produce_d  = 1'b1;
                            data_out_d = rx_shift_next[8:1];
                        end
                    end
                end
            end
            ST_TX_INHIBIT: begin
                // Own pull-down makes CLK edges here; the timer counts inhibit length instead.
                tmr_d = tmr_q + TW'(1);
                if (tmr_q == TW'(INHIBIT_CYC - 1)) begin
                    state_d   = ST_TX_START;
                    tmr_d     = '0;
                    bit_cnt_d = '0;
                    dat_pd_d  = 1'b1;
                end
            end
            ST_TX_START: begin
                if (bit_cnt_q == 4'd0) begin
                    bit_cnt_d = 4'd1;
                end else begin
                    bit_cnt_d = '0;
                    state_d   = ST_TX_BITS;
                end
            end
            ST_TX_BITS: begin
                if (clk_fall) begin
                    dat_pd_d   = ~tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[9:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(TX_BITS_LEN - 1)) state_d = ST_TX_ACK;
                end
            end
            ST_TX_ACK: begin
                // ACK status is not reported, so any falling edge ends the frame.
                dat_pd_d = 1'b0;
                if (clk_fall) state_d = ST_TX_WAITREL;
            end
            ST_TX_WAITREL: begin
                if (clk_s && dat_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && state_q != ST_TX_INHIBIT && !clk_fall && !clk_rise
            && tmr_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d   = ST_IDLE;
            dat_pd_d  = 1'b0;
            produce_d = 1'b0;
            bit_cnt_d = '0;
            tmr_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            tmr_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            dat_pd_q   <= 1'b0;
            consume_q  <= 1'b0;
            produce_q  <= 1'b0;
            data_out_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tmr_q      <= tmr_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            dat_pd_q   <= dat_pd_d;
            consume_q  <= consume_d;
            produce_q  <= produce_d;
            data_out_q <= data_out_d;
        end
    end

    assign ps2_clk_pd          = (state_q == ST_TX_INHIBIT) ||
                                 (state_q == ST_TX_START && bit_cnt_q == 4'd0);
    assign ps2_dat_pd          = dat_pd_q;
    assign bs_data_in_consume  = consume_q;
    assign bs_data_out_produce = produce_q;
    assign bs_data_out         = data_out_q;

endmodule

// File: tb/tb_bytestream_ps2.sv
// Bench for bytestream_ps2 at CLK_RATE=1 MHz with a behavioural PS/2 device on
// open-drain lines; optional BYTESTREAM_PS2_PARITY_CHECK_EN changes the frame model.
`timescale 1ns/1ps
module tb_bytestream_ps2;
    import bytestream_ps2_pkg::*;

    localparam int CLK_RATE    = 1000000;
    localparam int INHIBIT_CYC = CLK_RATE / 10000;
    localparam int TIMEOUT_CYC = CLK_RATE / 500;

    logic       clk, reset;
    logic       dev_clk_low, dev_dat_low;
    logic       ps2_clk_in, ps2_clk_pd, ps2_dat_in, ps2_dat_pd;
    logic [7:0] bs_data_in, bs_data_out;
    logic       bs_data_in_valid, bs_data_in_consume, bs_data_out_produce;

    assign ps2_clk_in = ~(ps2_clk_pd | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_pd | dev_dat_low);

    bytestream_ps2 #(.CLK_RATE(CLK_RATE)) dut (
        .clk(clk), .reset(reset),
        .ps2_clk_in(ps2_clk_in), .ps2_clk_pd(ps2_clk_pd),
        .ps2_dat_in(ps2_dat_in), .ps2_dat_pd(ps2_dat_pd),
        .bs_data_in(bs_data_in), .bs_data_in_valid(bs_data_in_valid),
        .bs_data_in_consume(bs_data_in_consume),
        .bs_data_out(bs_data_out), .bs_data_out_produce(bs_data_out_produce)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_rd;
    int         n_consume;
    int         n_cmp, n_err;

    initial n_consume = 0;
    always @(negedge clk) begin
        if (bs_data_out_produce) got_q.push_back(bs_data_out);
        if (bs_data_in_consume) n_consume = n_consume + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, got_q.size() - got_rd, exp_q.size());
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            check({tag, "_byte"}, got_q[got_rd], exp_q.pop_front());
            got_rd++;
        end
        exp_q.delete();
        got_rd = got_q.size();
    endtask

    // reference model: frame bits [0]=start [8:1]=data [9]=parity [10]=stop
    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic start,
                                               input logic stop, input logic par_flip);
        logic par;
        par = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
        return {stop, par ^ par_flip, d, start};
    endfunction

    function automatic logic frame_valid(input logic [10:0] f);
        logic ok;
        ok = (f[0] == 1'b0) && (f[10] == 1'b1);
`ifdef BYTESTREAM_PS2_PARITY_CHECK_EN
        ok = ok && (($countones(f[9:1]) % 2) == 1);
`endif
        return ok;
    endfunction

    // device -> host: one bit per ~80 cycles, data set up well before each fall
    task automatic dev_send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            dev_dat_low = ~frame[i];
            wait_cyc(20);
            dev_clk_low = 1'b1;
            wait_cyc(40);
            dev_clk_low = 1'b0;
            wait_cyc(20);
        end
        dev_dat_low = 1'b0;
        wait_cyc(20);
    endtask

    // host -> device: measure inhibit, clock out 10 bits, then ACK
    task automatic dev_receive(input logic [7:0] b, input string tag);
        int          t, lowc;
        logic [9:0]  bits;
        logic        par;
        t = 0;
        while (!ps2_clk_pd && t < 2000) begin wait_cyc(1); t++; end
        check({tag, "_inhibit_seen"}, ps2_clk_pd, 1'b1);
        lowc = 0;
        while (ps2_clk_pd && lowc < 1000) begin wait_cyc(1); lowc++; end
        check({tag, "_inhibit_len_ok"}, (lowc >= INHIBIT_CYC && lowc <= INHIBIT_CYC + 1), 1'b1);
        wait_cyc(5);
        check({tag, "_start_bit"}, ps2_dat_in, 1'b0);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            wait_cyc(40);
            bits[i] = ps2_dat_in;
            dev_clk_low = 1'b0;
            wait_cyc(40);
        end
        par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
        check({tag, "_bits"}, bits, {1'b1, par, b});
        dev_dat_low = 1'b1;
        wait_cyc(10);
        dev_clk_low = 1'b1;
        wait_cyc(40);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        wait_cyc(40);
        check({tag, "_idle_after"}, dut.state_q, ST_IDLE);
    endtask

    task automatic host_offer(input logic [7:0] b);
        int t;
        bs_data_in       = b;
        bs_data_in_valid = 1'b1;
        t = 0;
        while (!bs_data_in_consume && t < 50) begin wait_cyc(1); t++; end
        bs_data_in_valid = 1'b0;
        bs_data_in       = 8'($urandom);
    endtask

    task automatic host_send(input logic [7:0] b, input string tag);
        int c0;
        c0 = n_consume;
        host_offer(b);
        dev_receive(b, tag);
        check({tag, "_consume_once"}, n_consume - c0, 1);
    endtask

    task automatic dev_frame(input logic [10:0] f, input string tag);
        if (frame_valid(f)) exp_q.push_back(f[8:1]);
        dev_send_bits(f, 11);
        wait_cyc(20);
        check_rx(tag);
    endtask

    initial begin
        logic [7:0] v69;
        logic [9:0] bits69;
        int         c0, p0, t;
        n_cmp = 0; n_err = 0; got_rd = 0;
        reset = 1'b1; dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        bs_data_in = 8'h00; bs_data_in_valid = 1'b0;
        wait_cyc(5);
        check("rst_state", dut.state_q, ST_IDLE);
        check("rst_clk_pd", ps2_clk_pd, 1'b0);
        check("rst_dat_pd", ps2_dat_pd, 1'b0);
        check("rst_consume", bs_data_in_consume, 1'b0);
        check("rst_produce", bs_data_out_produce, 1'b0);
        check("rst_data_out", bs_data_out, 8'h00);
        reset = 1'b0;
        wait_cyc(10);

        // host sends 0x69; LSB-first data bits 1,0,0,1,0,1,1,0, parity 1, stop 1
        v69 = 8'h69;
        bits69 = 10'b11_0110_1001;
        check("tx69_model", {1'b1, (($countones(v69) % 2) == 0) ? 1'b1 : 1'b0, v69}, bits69);
        host_send(v69, "tx69");
        wait_cyc(50);

        // device echoes 0x69
        dev_frame(make_frame(8'h69, 1'b0, 1'b1, 1'b0), "rx69");
        check("rx69_data_out", bs_data_out, 8'h69);

        // 0x00 with parity 0 (wrong for odd parity)
        dev_frame({1'b1, 1'b0, 8'h00, 1'b0}, "rx00_badpar");

        // device stops after 5 bits, frame abandoned by the 2 ms timeout
        p0 = got_q.size();
        dev_send_bits(make_frame(8'h55, 1'b0, 1'b1, 1'b0), 5);
        wait_cyc(1900);
        check("trunc_still_rx", dut.state_q == ST_IDLE, 1'b0);
        wait_cyc(100);
        check("trunc_idle", dut.state_q, ST_IDLE);
        check("trunc_no_produce", got_q.size() - p0, 0);
        got_rd = got_q.size();
        dev_frame(make_frame(8'hAA, 1'b0, 1'b1, 1'b0), "rxAA");

        // randomized mix of host and device frames, some corrupted
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            int         kind;
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                host_send(d, "rnd_tx");
            end else begin
                kind = $urandom_range(0, 5);
                dev_frame(make_frame(d, kind == 0, kind != 1, kind == 2), "rnd_rx");
            end
            wait_cyc($urandom_range(5, 60));
        end

        // reset during inhibit
        host_offer(8'h3C);
        wait_cyc(30);
        check("rstinh_clk_pd_before", ps2_clk_pd, 1'b1);
        reset = 1'b1;
        #1;
        check("rstinh_clk_pd", ps2_clk_pd, 1'b0);
        check("rstinh_dat_pd", ps2_dat_pd, 1'b0);
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(10);

        // reset while a 0 data bit is being driven
        host_offer(8'h00);
        t = 0;
        while (ps2_clk_pd && t < 1000) begin wait_cyc(1); t++; end
        wait_cyc(5);
        dev_clk_low = 1'b1;
        wait_cyc(40);
        dev_clk_low = 1'b0;
        wait_cyc(20);
        check("rstbits_dat_pd_before", ps2_dat_pd, 1'b1);
        c0 = n_consume;
        p0 = got_q.size();
        reset = 1'b1;
        #1;
        check("rstbits_clk_pd", ps2_clk_pd, 1'b0);
        check("rstbits_dat_pd", ps2_dat_pd, 1'b0);
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(500);
        check("rstbits_state", dut.state_q, ST_IDLE);
        check("rstbits_no_consume", n_consume - c0, 0);
        check("rstbits_no_produce", got_q.size() - p0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bytestream_ps2.md
BYTESTREAM_PS2 -- requirements
Module: bytestream_ps2

Interface
REQ-001 SHALL have parameter CLK_RATE, default 50000000, meaning the clk frequency in Hz; all PS/2 timing is derived from it.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ps2_clk_in, input, 1 bit: the PS/2 CLK line level, asynchronous.
REQ-005 SHALL have port ps2_clk_pd, output, 1 bit: 1 pulls PS/2 CLK low, 0 releases it.
REQ-006 SHALL have port ps2_dat_in, input, 1 bit: the PS/2 DATA line level, asynchronous.
REQ-007 SHALL have port ps2_dat_pd, output, 1 bit: 1 pulls PS/2 DATA low, 0 releases it.
REQ-008 SHALL have port bs_data_in, input, 8 bits: the byte to transmit to the device.
REQ-009 SHALL have port bs_data_in_valid, input, 1 bit: bs_data_in holds a byte to send.
REQ-010 SHALL have port bs_data_in_consume, output, 1 bit: one-cycle pulse meaning bs_data_in has been accepted.
REQ-011 SHALL have port bs_data_out, output, 8 bits: the last byte received from the device.
REQ-012 SHALL have port bs_data_out_produce, output, 1 bit: one-cycle pulse meaning bs_data_out holds a new byte.

Function
REQ-013 SHALL pass ps2_clk_in and ps2_dat_in through 2-FF synchronisers, then detect CLK falling and rising edges on the synchronised value.
REQ-014 SHALL use states IDLE, RX, TX_INHIBIT, TX_START, TX_BITS, TX_ACK, TX_WAITREL.
REQ-015 SHALL, in IDLE, move to RX when a CLK falling edge occurs; RX takes priority over a pending bs_data_in_valid in the same cycle.
REQ-016 SHALL, in RX, sample DATA on each CLK falling edge for 11 bits, LSB-first: start(0), d0..d7, odd parity, stop(1).
REQ-017 SHALL, after the 11th bit, return to IDLE and, if the frame is valid, load bs_data_out and pulse bs_data_out_produce for exactly one cycle.
REQ-018 SHALL treat a frame as valid only when start=0 and stop=1; invalid frames are dropped silently.
REQ-019 SHALL, in IDLE with bs_data_in_valid=1 and both synchronised lines high, latch bs_data_in, pulse bs_data_in_consume for one cycle and enter TX_INHIBIT.
REQ-020 SHALL, in TX_INHIBIT, drive ps2_clk_pd=1 for CLK_RATE/10000 cycles (100 us).
REQ-021 SHALL, in TX_START, assert ps2_dat_pd=1 (start bit), then release ps2_clk_pd on the following cycle and enter TX_BITS.
REQ-022 SHALL, in TX_BITS, on each CLK falling edge, drive the next bit of d0..d7, odd parity, stop(1) onto DATA (ps2_dat_pd = ~bit); after the stop bit is driven, DATA is released.
REQ-023 SHALL, in TX_ACK, wait for a CLK falling edge with DATA low (device ACK), then enter TX_WAITREL; a missing ACK is ignored.
REQ-024 SHALL, in TX_WAITREL, wait until both lines are high, then enter IDLE.
REQ-025 SHALL, in every state except IDLE and TX_INHIBIT, abort to IDLE with both pull-downs released and no produce pulse if no CLK edge occurs for CLK_RATE/500 cycles (2 ms).
REQ-026 SHALL ignore bs_data_in_valid outside IDLE; consume pulses at most once per frame.
REQ-027 SHALL keep ps2_clk_pd=0 in every state except TX_INHIBIT and the first cycle of TX_START.

Reset
REQ-028 SHALL, while reset=1, force state IDLE, ps2_clk_pd=0, ps2_dat_pd=0, bs_data_in_consume=0, bs_data_out_produce=0, bs_data_out=8'h00, and clear all counters and shift registers.
REQ-029 SHALL, on reset in mid-frame, abandon the frame; no consume or produce pulse is emitted for it.

Configuration
REQ-030 SHALL, when BYTESTREAM_PS2_PARITY_CHECK_EN is defined, additionally require odd parity over d0..d7 plus the parity bit for a received frame to be valid; when it is undefined, the parity bit is ignored.

Structure
REQ-031 SHALL place the state enum, frame length (11) and the inhibit/timeout divisor constants in package bytestream_ps2_pkg.
REQ-032 SHALL implement synchronisation and edge detection in one sub-module ps2_line_sync, instantiated once per line.

Verification
REQ-033 SHALL verify: CLK_RATE=1000000, send 8'h69 -> consume pulses once; CLK held low for 100 cycles; device receives bits 1,0,0,1,0,1,1,0, parity 1, stop 1, then ACKs.
REQ-034 SHALL verify: device echoes 8'h69 -> exactly one bs_data_out_produce pulse, with bs_data_out=8'h69.
REQ-035 SHALL verify: device sends 8'h00 with parity 0 -> no produce pulse when the macro is defined, one pulse with 8'h00 when it is undefined.
REQ-036 SHALL verify: device stops after 5 bits -> after 2000 cycles (CLK_RATE=1000000) state is IDLE and no produce pulse occurs; a following 8'hAA frame is received correctly.
REQ-037 SHALL verify: reset asserted mid-TX -> both pull-downs drop immediately, and no consume or produce pulse occurs afterwards until new stimulus.
